// File: rtl/ds_dac_scheduler_pkg.sv
// Shared types and helpers for the delta-sigma DAC input scheduler.
// Sizes derive from the block parameters at elaboration time.
package ds_dac_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RAMP = 2'd2
   } ds_state_t;

   localparam int DEF_RATE_DIV = 256;
   localparam int CNT_W        = $clog2(DEF_RATE_DIV);

   // Offset-binary zero point: 1 << (width-1).
   function automatic logic [63:0] ds_mid(input int width);
      return 64'd1 << (width - 1);
   endfunction

   // $clog2 with a floor of one bit so single-entry vectors stay legal.
   function automatic int min1_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ds_dac_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches last_idx+1, last_idx+2, ...
// modulo N and grants the first requester found, only while en is high.
module rr_arbiter
   import ds_dac_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = min1_clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_idx,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic found_s;
   logic hit_s;
   int   pos_s;

   // Rotate-priority search starting just after the previous winner.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found_s = 1'b0;
      hit_s   = 1'b0;
      pos_s   = 0;
      for (int k = 1; k <= N; k++) begin
         pos_s      = (int'(last_idx) + k) % N;
         hit_s      = en && !found_s && req[pos_s];
         gnt[pos_s] = hit_s;
         gnt_idx    = hit_s ? IW'(pos_s) : gnt_idx;
         found_s    = found_s | hit_s;
      end
   end

endmodule

// File: rtl/ds_dac_scheduler.sv
// Paces one shared DAC input word among NUM_REQ sources with a fixed sample-rate
// divider and round-robin arbitration; ramps to mid-scale on disable to avoid pops.
module ds_dac_scheduler
   import ds_dac_pkg::*;
#(
   parameter  int WIDTH     = 16,
   parameter  int NUM_REQ   = 4,
   parameter  int RATE_DIV  = DEF_RATE_DIV,
   parameter  int RAMP_STEP = 64,
   localparam int IDX_W     = min1_clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [WIDTH-1:0]         dac_din,
   output logic                     sample_tick,
   output logic [IDX_W-1:0]         grant_idx,
   output logic                     underrun,
   output logic                     busy
);

   localparam int               RATE_CNT_W = (RATE_DIV == DEF_RATE_DIV) ? CNT_W : min1_clog2(RATE_DIV);
   localparam logic [RATE_CNT_W-1:0] CNT_LAST = RATE_CNT_W'(RATE_DIV - 1);
   localparam logic [WIDTH-1:0] MID      = WIDTH'(ds_mid(WIDTH));
   localparam logic [WIDTH-1:0] STEP     = WIDTH'(RAMP_STEP);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

   ds_state_t               state_r;
   ds_state_t               state_next_s;
   logic [RATE_CNT_W-1:0]   rate_cnt_r;
   logic [WIDTH-1:0]        dac_din_r;
   logic [WIDTH-1:0]        dac_next_s;
   logic [WIDTH-1:0]        ramp_val_s;
   logic [WIDTH-1:0]        sel_data_s;
   logic signed [WIDTH:0]   diff_s;
   logic [WIDTH:0]          mag_s;
   logic [IDX_W-1:0]        grant_idx_r;
   logic [IDX_W-1:0]        last_r;
   logic [IDX_W-1:0]        arb_idx_s;
   logic [NUM_REQ-1:0]      gnt_s;
   logic                    underrun_r;
   logic                    tick_s;
   logic                    arb_en_s;
   logic                    grant_s;

   assign tick_s   = (state_r != IDLE) && (rate_cnt_r == CNT_LAST);
   assign arb_en_s = tick_s && (state_r == RUN);
   assign grant_s  = |gnt_s;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .req      (req_valid),
      .last_idx (last_r),
      .en       (arb_en_s),
      .gnt      (gnt_s),
      .gnt_idx  (arb_idx_s)
   );

   assign sel_data_s = req_data[int'(arb_idx_s)*WIDTH +: WIDTH];

   // One ramp step toward mid-scale; snaps to MID when within one step so it never overshoots.
   always_comb begin
      diff_s     = signed'({1'b0, dac_din_r}) - signed'({1'b0, MID});
      mag_s      = diff_s[WIDTH] ? unsigned'(-diff_s) : unsigned'(diff_s);
      ramp_val_s = dac_din_r;
      if (mag_s <= {1'b0, STEP}) begin
         ramp_val_s = MID;
      end else if (diff_s[WIDTH]) begin
         ramp_val_s = dac_din_r + STEP;
      end else begin
         ramp_val_s = dac_din_r - STEP;
      end
   end

   // Next-state decode; enable is sampled every cycle, not only on ticks.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (enable) begin
               state_next_s = RUN;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            if (!enable) begin
               state_next_s = RAMP;
            end else begin
               state_next_s = RUN;
            end
         end
         RAMP: begin
            if (enable) begin
               state_next_s = RUN;
            end else if ((dac_din_r == MID) || (tick_s && (ramp_val_s == MID))) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = RAMP;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Next DAC word: only tick cycles may change it outside IDLE.
   always_comb begin
      dac_next_s = dac_din_r;
      case (state_r)
         IDLE: dac_next_s = MID;
         RUN: begin
            if (tick_s && grant_s) begin
               dac_next_s = sel_data_s;
            end else begin
               dac_next_s = dac_din_r;
            end
         end
         RAMP: begin
            if (tick_s) begin
               dac_next_s = ramp_val_s;
            end else begin
               dac_next_s = dac_din_r;
            end
         end
         default: dac_next_s = MID;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Sample-period counter; parked at zero whenever the block is or becomes idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rate_cnt_r <= '0;
      end else if ((state_r == IDLE) || (state_next_s == IDLE) || (rate_cnt_r == CNT_LAST)) begin
         rate_cnt_r <= '0;
      end else begin
         rate_cnt_r <= rate_cnt_r + RATE_CNT_W'(1);
      end
   end

   // Datapath: DAC word, grant bookkeeping and the registered underrun pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dac_din_r   <= MID;
         grant_idx_r <= '0;
         last_r      <= LAST_RST;
         underrun_r  <= 1'b0;
      end else begin
         dac_din_r  <= dac_next_s;
         underrun_r <= arb_en_s && !grant_s;
         if (arb_en_s && grant_s) begin
            grant_idx_r <= arb_idx_s;
            last_r      <= arb_idx_s;
         end else begin
            grant_idx_r <= grant_idx_r;
            last_r      <= last_r;
         end
      end
   end

   assign req_ready   = gnt_s;
   assign dac_din     = dac_din_r;
   assign sample_tick = tick_s;
   assign grant_idx   = grant_idx_r;
   assign underrun    = underrun_r;
   assign busy        = (state_r != IDLE);

endmodule
